ysyx_23060124_rf_wport_arbiter: RTL and testbench

Arbiter and sequencer for the single write port of the integer register file. It takes writeback requests from two producers, the EXU (ALU/CSR results) and the LSU (load results), and grants at most one per cycle in round-robin order. The granted write is registered and driven onto the register file's `wen`/`waddr`/`wdata` one cycle later. It also keeps a saturating count of cycles in which a requester was held off, for performance analysis.

---
 rtl/ysyx_23060124_rf_wport_arbiter.sv | 96 +++++++++
 tb/tb_ysyx_23060124_rf_wport_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060124_rf_wport_arbiter.sv
// Round-robin arbiter for the integer register-file write port (EXU vs LSU).
// The accepted write is registered onto rf_wen/rf_waddr/rf_wdata; lost arbitration cycles are counted.
module ysyx_23060124_rf_wport_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic [ADDR_W-1:0] exu_waddr,
  input  logic [DATA_W-1:0] exu_wdata,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_waddr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    GRANT_EXU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

  grant_e            last_grant;
  logic              exu_grant;
  logic              lsu_grant;
  logic              any_grant;
  logic [ADDR_W-1:0] sel_waddr;
  logic [DATA_W-1:0] sel_wdata;
  logic              stall_event;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    exu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (!reset) begin
      if (exu_valid && lsu_valid) begin
        exu_grant = (last_grant == GRANT_LSU);
        lsu_grant = (last_grant == GRANT_EXU);
      end else begin
        exu_grant = exu_valid;
        lsu_grant = lsu_valid;
      end
    end
  end

  assign exu_ready = exu_grant;
  assign lsu_ready = lsu_grant;
  assign any_grant = exu_grant | lsu_grant;

  always_comb begin
    sel_waddr = exu_waddr;
    sel_wdata = exu_wdata;
    if (lsu_grant) begin
      sel_waddr = lsu_waddr;
      sel_wdata = lsu_wdata;
    end
  end

  assign stall_event = (exu_valid & ~exu_grant) ^ (lsu_valid & ~lsu_grant);

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= GRANT_LSU;
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else begin
      rf_wen <= 1'b0;
      if (any_grant) begin
        last_grant <= lsu_grant ? GRANT_LSU : GRANT_EXU;
        // x0 writes are accepted but never reach the register file.
        rf_wen     <= |sel_waddr;
        rf_waddr   <= sel_waddr;
        rf_wdata   <= sel_wdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_event && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_rf_wport_arbiter.sv
// Self-checking bench for the register-file write-port arbiter.
// A round-robin preference model predicts readies, the registered write and the stall count.
module tb_ysyx_23060124_rf_wport_arbiter;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              exu_valid, lsu_valid;
  logic              exu_ready, lsu_ready;
  logic [ADDR_W-1:0] exu_waddr, lsu_waddr;
  logic [DATA_W-1:0] exu_wdata, lsu_wdata;
  logic              rf_wen;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  stall_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: who wins the next tie, plus the write the register file should see.
  int              tie_to_lsu;
  logic            m_wen;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  int              m_stall;
  logic            g_exu, g_lsu;

  always #5 clock = ~clock;

  ysyx_23060124_rf_wport_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .exu_valid(exu_valid),
    .exu_ready(exu_ready),
    .exu_waddr(exu_waddr),
    .exu_wdata(exu_wdata),
    .lsu_valid(lsu_valid),
    .lsu_ready(lsu_ready),
    .lsu_waddr(lsu_waddr),
    .lsu_wdata(lsu_wdata),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .stall_cnt(stall_cnt)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check readies, predict, cross the edge, check registered outputs.
  task automatic apply_stimulus(input logic rst,
                                input logic ev, input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed,
                                input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
    reset     = rst;
    exu_valid = ev;
    exu_waddr = ea;
    exu_wdata = ed;
    lsu_valid = lv;
    lsu_waddr = la;
    lsu_wdata = ld;
    #1;
    if (rst) begin
      g_exu = 1'b0;
      g_lsu = 1'b0;
    end else if (ev && lv) begin
      g_exu = (tie_to_lsu == 0);
      g_lsu = (tie_to_lsu == 1);
    end else begin
      g_exu = ev;
      g_lsu = lv;
    end
    check_output("exu_ready", 64'(exu_ready), 64'(g_exu));
    check_output("lsu_ready", 64'(lsu_ready), 64'(g_lsu));

    if (rst) begin
      m_wen      = 1'b0;
      m_waddr    = '0;
      m_wdata    = '0;
      m_stall    = 0;
      tie_to_lsu = 0;
    end else begin
      if (ev && lv) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
      m_wen = 1'b0;
      if (g_exu) begin
        m_wen      = (ea != 0);
        m_waddr    = ea;
        m_wdata    = ed;
        tie_to_lsu = 1;
      end else if (g_lsu) begin
        m_wen      = (la != 0);
        m_waddr    = la;
        m_wdata    = ld;
        tie_to_lsu = 0;
      end
    end

    @(posedge clock);
    #1;
    check_output("rf_wen",    64'(rf_wen),    64'(m_wen));
    check_output("rf_waddr",  64'(rf_waddr),  64'(m_waddr));
    check_output("rf_wdata",  64'(rf_wdata),  64'(m_wdata));
    check_output("stall_cnt", 64'(stall_cnt), 64'(m_stall));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Producers that hold each request until granted; optional forced contention and random resets.
  task automatic run_random(input int cycles, input int rst_odds, input bit contend);
    logic              ep, lp, rst;
    logic [ADDR_W-1:0] ea, la;
    logic [DATA_W-1:0] ed, ld;
    ep = 1'b0;
    lp = 1'b0;
    ea = '0;
    la = '0;
    ed = '0;
    ld = '0;
    for (int i = 0; i < cycles; i++) begin
      if (!ep && (contend || $urandom_range(0, 2) != 0)) begin
        ep = 1'b1;
        ea = contend ? ADDR_W'($urandom_range(1, 31)) : ADDR_W'($urandom_range(0, 31));
        ed = $urandom;
      end
      if (!lp && (contend || $urandom_range(0, 2) != 0)) begin
        lp = 1'b1;
        la = contend ? ADDR_W'($urandom_range(1, 31)) : ADDR_W'($urandom_range(0, 31));
        ld = $urandom;
      end
      rst = (rst_odds > 0) && ($urandom_range(0, rst_odds - 1) == 0);
      apply_stimulus(rst, ep, ea, ed, lp, la, ld);
      if (rst) begin
        ep = 1'b0;
        lp = 1'b0;
      end else begin
        if (g_exu) ep = 1'b0;
        if (g_lsu) lp = 1'b0;
      end
    end
  endtask

  initial begin
    tie_to_lsu = 0;
    m_wen      = 1'b0;
    m_waddr    = '0;
    m_wdata    = '0;
    m_stall    = 0;

    $display("[TB] reset then idle");
    do_reset();
    idle(5);

    $display("[TB] EXU-only write");
    apply_stimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    check_output("exu_only_wdata", 64'(rf_wdata), 64'h0000_0000_DEAD_BEEF);
    idle(1);

    $display("[TB] contention sequence 1,3,2,4");
    do_reset();
    apply_stimulus(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h33);
    check_output("seq_w0", 64'(rf_waddr), 64'd1);
    apply_stimulus(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33);
    check_output("seq_w1", 64'(rf_waddr), 64'd3);
    apply_stimulus(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44);
    check_output("seq_w2", 64'(rf_waddr), 64'd2);
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd4, 32'h44);
    check_output("seq_w3", 64'(rf_waddr), 64'd4);
    check_output("seq_stall", 64'(stall_cnt), 64'd3);
    idle(1);

    $display("[TB] x0 write still updates round-robin");
    apply_stimulus(1'b0, 1'b1, 5'd8, 32'h88, 1'b0, '0, '0);
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'h1234);
    check_output("x0_wen", 64'(rf_wen), 64'd0);
    apply_stimulus(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
    check_output("x0_tie_exu", 64'(rf_waddr), 64'd9);
    idle(1);

    $display("[TB] back-to-back writes to the same rd");
    apply_stimulus(1'b0, 1'b1, 5'd6, 32'h600, 1'b0, '0, '0);
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd6, 32'h601);
    check_output("b2b_wdata", 64'(rf_wdata), 64'h601);

    $display("[TB] stall counter saturation");
    do_reset();
    run_random(20, 0, 1'b1);
    check_output("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
    run_random(5, 0, 1'b1);

    $display("[TB] reset during an EXU handshake");
    idle(1);
    apply_stimulus(1'b0, 1'b1, 5'd13, 32'hD0, 1'b0, '0, '0);
    apply_stimulus(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, '0, '0);
    check_output("rst_mid_wen", 64'(rf_wen), 64'd0);
    apply_stimulus(1'b0, 1'b1, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hC2);
    check_output("rst_mid_tie_exu", 64'(rf_waddr), 64'd11);
    idle(2);

    $display("[TB] randomized traffic with occasional reset");
    run_random(300, 40, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
